// File: rtl/bus_pkg.sv
// Shared bus definitions: access FSM state encoding, abort data word and slave decode.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } bus_state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    function automatic logic [3:0] slave_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'b00:   oh = 4'b0001;
            2'b01:   oh = 4'b0010;
            2'b10:   oh = 4'b0100;
            2'b11:   oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_demux4_mux.sv
// 32-bit 4-to-1 select mux used on the slave read-data return path.
module bus_demux4_mux (
    input  logic [1:0]  sel,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    output logic [31:0] y
);

    // Pure combinational select.
    always_comb begin
        y = 32'h0000_0000;
        case (sel)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            2'b11:   y = d3;
            default: y = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/bus_demux4.sv
// Single-master to four-slave bus demultiplexer with per-access timeout abort.
module bus_demux4
    import bus_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = BUS_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [3:0]  s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [3:0]  s_ack,
    input  logic [31:0] s_rdata0,
    input  logic [31:0] s_rdata1,
    input  logic [31:0] s_rdata2,
    input  logic [31:0] s_rdata3
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    bus_state_e    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic [3:0]    s_req_q, s_req_d;
    logic [31:0]   mux_rdata_s;
    logic          sel_ack_s;

    bus_demux4_mux u_rdata_mux (
        .sel (idx_q),
        .d0  (s_rdata0),
        .d1  (s_rdata1),
        .d2  (s_rdata2),
        .d3  (s_rdata3),
        .y   (mux_rdata_s)
    );

    assign sel_ack_s = s_ack[idx_q];

    // Next-state and registered-output computation; s_req/cpu_ack are precomputed
    // for the state being entered so they line up with ACCESS/RESP.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        s_req_d = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    idx_d   = cpu_addr[31:30];
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
                    s_req_d = slave_onehot(cpu_addr[31:30]);
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Ack is tested first so it wins over a timeout in the same cycle.
                if (sel_ack_s) begin
                    rdata_d = we_q ? 32'h0000_0000 : mux_rdata_s;
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    s_req_d = slave_onehot(idx_q);
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            cnt_q   <= '0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            s_req_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            s_req_q <= s_req_d;
        end
    end

    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign s_req     = s_req_q;
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_demux4.sv
// Self-checking bench for bus_demux4: directed cases plus randomized accesses
// checked against a transaction-level model of the access/timeout rules.
module tb_bus_demux4;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [3:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_ack;
    logic [31:0] s_rdata0, s_rdata1, s_rdata2, s_rdata3;

    int tests_run;
    int tests_failed;

    bus_demux4 #(.TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack),
        .s_rdata0(s_rdata0), .s_rdata1(s_rdata1), .s_rdata2(s_rdata2), .s_rdata3(s_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fill every slave with random data, then put the wanted word on slave idx.
    task automatic set_rdata(input int idx, input logic [31:0] val);
        s_rdata0 = $urandom; s_rdata1 = $urandom; s_rdata2 = $urandom; s_rdata3 = $urandom;
        case (idx)
            0: s_rdata0 = val;
            1: s_rdata1 = val;
            2: s_rdata2 = val;
            default: s_rdata3 = val;
        endcase
    endtask

    // One complete access; caller is positioned at a negedge with the DUT idle.
    // ack_delay = ACCESS cycles the slave waits before acking; noise = unselected acks.
    task automatic run_access(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdval,
                              input int ack_delay, input logic [3:0] noise);
        int          idx;
        logic [3:0]  oh;
        int          exp_cycles;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          cycles;
        idx        = int'(addr[31:30]);
        oh         = 4'b0001 << idx;
        exp_err    = (ack_delay >= TO);
        exp_cycles = exp_err ? TO : ack_delay + 1;
        exp_rdata  = exp_err ? 32'hDEADBEEF : (we ? 32'h0000_0000 : rdval);

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        set_rdata(idx, rdval);
        s_ack = 4'b0000;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom;
        cycles = 0;
        while (cpu_ack !== 1'b1 && cycles < 40) begin
            cycles++;
            tests_run++;
            if (s_req !== oh || s_we !== we || s_addr !== addr || s_wdata !== wdata) begin
                tests_failed++;
                $display("FAIL %s access_drive cyc%0d: got req=%b we=%b a=%h d=%h want req=%b we=%b a=%h d=%h",
                         name, cycles, s_req, s_we, s_addr, s_wdata, oh, we, addr, wdata);
            end
            s_ack = noise & ~oh;
            if (cycles - 1 == ack_delay) s_ack = s_ack | oh;
            @(negedge clk);
        end
        s_ack = 4'b0000;
        tests_run++;
        if (cycles !== exp_cycles || cpu_err !== exp_err || cpu_rdata !== exp_rdata || s_req !== 4'b0000) begin
            tests_failed++;
            $display("FAIL %s response: got cyc=%0d err=%b rdata=%h sreq=%b want cyc=%0d err=%b rdata=%h sreq=0000",
                     name, cycles, cpu_err, cpu_rdata, s_req, exp_cycles, exp_err, exp_rdata);
        end
        set_rdata(idx, $urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tests_run++;
        if (cpu_ack !== 1'b0 || cpu_err !== exp_err || cpu_rdata !== exp_rdata || s_req !== 4'b0000) begin
            tests_failed++;
            $display("FAIL %s after_resp: got ack=%b err=%b rdata=%h sreq=%b want ack=0 err=%b rdata=%h sreq=0000",
                     name, cpu_ack, cpu_err, cpu_rdata, s_req, exp_err, exp_rdata);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if (s_req !== 4'b0000 || cpu_ack !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0 ||
            s_we !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s: got req=%b ack=%b err=%b rdata=%h we=%b a=%h d=%h want all zero",
                     name, s_req, cpu_ack, cpu_err, cpu_rdata, s_we, s_addr, s_wdata);
        end
    endtask

    task automatic test_reset();
        check_all_zero("reset_state");
        rst_n = 1'b1;
        // Request presented together with reset release is sampled on the next edge.
        run_access("first_after_reset", 1'b0, 32'h8000_0004, 32'h0, 32'h0BAD_F00D, 0, 4'b0000);
    endtask

    task automatic test_directed();
        run_access("read_slave1", 1'b0, 32'h4000_0010, 32'h0, 32'h1234_5678, 2, 4'b0000);
        run_access("write_slave3", 1'b1, 32'hC000_0000, 32'hA5A5_A5A5, 32'h7777_7777, 0, 4'b0000);
        run_access("timeout_slave2", 1'b0, 32'h8000_0000, 32'h0, 32'h1111_1111, 1000, 4'b0000);
        run_access("wrong_slave_ack", 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_0000, 4, 4'b1000);
        run_access("ack_at_last_cycle", 1'b0, 32'h4000_0000, 32'h0, 32'h5555_AAAA, TO - 1, 4'b0000);
        run_access("ok_after_timeout", 1'b0, 32'h8000_0008, 32'h0, 32'h2468_ACE0, 1, 4'b0000);
    endtask

    task automatic test_reset_mid_access();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000_0040; cpu_wdata = 32'h1357_9BDF;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_access");
        s_ack = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * TO; i++) begin
            @(negedge clk);
            tests_run++;
            if (cpu_ack !== 1'b0 || s_req !== 4'b0000) begin
                tests_failed++;
                $display("FAIL no_completion_after_reset cyc%0d: got ack=%b sreq=%b want ack=0 sreq=0000",
                         i, cpu_ack, s_req);
            end
        end
        s_ack = 4'b0000;
        run_access("after_reset_access", 1'b0, 32'h0000_0100, 32'h0, 32'h9ABC_DEF0, 1, 4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        int          acks;
        int          last_ack;
        for (int k = 0; k < 4; k++) vals[k] = $urandom;
        s_rdata0 = vals[0]; s_rdata1 = vals[1]; s_rdata2 = vals[2]; s_rdata3 = vals[3];
        s_ack = 4'b1111;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000_0200; cpu_wdata = 32'h0;
        acks = 0;
        last_ack = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                acks++;
                tests_run++;
                if ((last_ack >= 0 && i - last_ack != 3) || cpu_rdata !== vals[1] || cpu_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL back_to_back_resp at %0d: got gap=%0d rdata=%h err=%b want gap=3 rdata=%h err=0",
                             i, i - last_ack, cpu_rdata, cpu_err, vals[1]);
                end
                last_ack = i;
            end
        end
        tests_run++;
        if (acks != 10) begin
            tests_failed++;
            $display("FAIL back_to_back_count: got %0d acks want 10", acks);
        end
        cpu_req = 1'b0;
        s_ack = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            int          d;
            a = $urandom;
            d = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
            run_access($sformatf("random%0d", n), 1'($urandom), a, $urandom, $urandom, d, 4'($urandom));
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        s_ack = 4'b0000;
        s_rdata0 = 32'h0; s_rdata1 = 32'h0; s_rdata2 = 32'h0; s_rdata3 = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
